// File: rtl/bram_wr_pkg.sv
// Shared widths, per-stream state type and BRAM address packing for the
// L1 stream buffer write/read paths.
package bram_wr_pkg;
    localparam int DATA_WIDTH      = 64;
    localparam int WAYS            = 8;
    localparam int BEAT_W          = WAYS * DATA_WIDTH;
    localparam int RAM_DEPTH       = 512;
    localparam int ADDR_WIDTH      = $clog2(RAM_DEPTH);
    localparam int l1_nstrms       = 16;
    localparam int l1_nstrms_width = $clog2(l1_nstrms);
    localparam int l1_ncl          = 16;
    localparam int l1_ncl_width    = $clog2(l1_ncl);

    // Address field offsets inside {st, cl, half}
    localparam int HALF_OFS = 0;
    localparam int CL_OFS   = 1;
    localparam int ST_OFS   = 1 + l1_ncl_width;

    typedef logic [l1_nstrms_width-1:0] st_t;
    typedef logic [l1_ncl_width-1:0]    cl_t;
    typedef logic [l1_ncl_width:0]      cnt_t;
    typedef logic [ADDR_WIDTH-1:0]      addr_t;
    typedef logic [BEAT_W-1:0]          beat_t;

    localparam cnt_t CNT_FULL = cnt_t'(l1_ncl);

    typedef struct packed {
        cl_t  head;   // next line slot to fill
        logic half;   // 1: first half of the head line already written
        cnt_t count;  // lines reserved or filled, not yet freed
    } strm_st_t;

    function automatic addr_t mk_addr(st_t st, cl_t cl, logic half);
        return {st, cl, half};
    endfunction
endpackage

// File: rtl/bram_wr_ctrl_if.sv
// Beat input, BRAM write port, line announce and free return of one channel.
interface bram_wr_ctrl_if;
    import bram_wr_pkg::*;

    logic                 i_v;
    logic                 i_r;
    st_t                  i_st;
    beat_t                i_d;
    logic                 o_we;
    addr_t                o_wa;
    beat_t                o_wd;
    logic                 i_free_v;
    st_t                  i_free_st;
    logic                 o_cl_v;
    st_t                  o_cl_st;
    cl_t                  o_cl_idx;
    logic [l1_nstrms-1:0] o_full;
    logic                 o_err;

    modport master (
        output i_v, i_st, i_d, i_free_v, i_free_st,
        input  i_r, o_we, o_wa, o_wd, o_cl_v, o_cl_st, o_cl_idx, o_full, o_err
    );

    modport slave (
        input  i_v, i_st, i_d, i_free_v, i_free_st,
        output i_r, o_we, o_wa, o_wd, o_cl_v, o_cl_st, o_cl_idx, o_full, o_err
    );
endinterface

// File: rtl/bram_wr_strm_tbl.sv
// Per-stream {head, half, count} table with one accept and one free port.
// A same-stream first-half accept and free in one cycle leave count unchanged.
module bram_wr_strm_tbl
    import bram_wr_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_v,
    input  st_t                  acc_st,
    input  logic                 free_v,
    input  st_t                  free_st,
    output strm_st_t             acc_rd,
    output strm_st_t             free_rd,
    output logic [l1_nstrms-1:0] full
);
    strm_st_t tbl [l1_nstrms];

    assign acc_rd  = tbl[acc_st];
    assign free_rd = tbl[free_st];

    // Current full status per stream
    always_comb begin
        full = '0;
        for (int s = 0; s < l1_nstrms; s++)
            full[s] = (tbl[s].count == CNT_FULL);
    end

    // Per-stream state update: accept advances half/head, count nets inc/dec
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < l1_nstrms; s++)
                tbl[s] <= '0;
        end else begin
            for (int s = 0; s < l1_nstrms; s++) begin
                logic inc, dec;
                inc = acc_v && (acc_st == st_t'(s)) && !tbl[s].half;
                dec = free_v && (free_st == st_t'(s));
                if (acc_v && (acc_st == st_t'(s))) begin
                    tbl[s].half <= ~tbl[s].half;
                    if (tbl[s].half)
                        tbl[s].head <= tbl[s].head + 1'b1;
                end
                if (inc && !dec)
                    tbl[s].count <= tbl[s].count + 1'b1;
                else if (dec && !inc)
                    tbl[s].count <= tbl[s].count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/bram_wr_ctrl.sv
// Write-side controller for one L1 stream BRAM channel: per-stream circular
// line allocation, BRAM write port, line-complete announce, free returns.
module bram_wr_ctrl
    import bram_wr_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    bram_wr_ctrl_if.slave bus
);
    if (ADDR_WIDTH != l1_nstrms_width + l1_ncl_width + 1) begin : g_bad_addr
        $error("ADDR_WIDTH must equal stream + line + half bits");
    end

    strm_st_t             st_a, st_f;
    logic                 rdy, acc, free_ok, free_bad;
    logic [l1_nstrms-1:0] full_now;

    logic                 we_q, cl_v_q, err_q;
    addr_t                wa_q;
    beat_t                wd_q;
    st_t                  cl_st_q;
    cl_t                  cl_idx_q;
    logic [l1_nstrms-1:0] full_q;

    // A second half always has its line reserved; a first half needs room.
    assign rdy = st_a.half | (st_a.count != CNT_FULL);
    assign acc = bus.i_v & rdy;

    // A free is legal only if a completed line exists to release.
    assign free_ok  = bus.i_free_v && (st_f.count != '0) &&
                      !((st_f.count == cnt_t'(1)) && st_f.half);
    assign free_bad = bus.i_free_v && !free_ok;

    bram_wr_strm_tbl u_tbl (
        .clk     (clk),
        .reset   (reset),
        .acc_v   (acc),
        .acc_st  (bus.i_st),
        .free_v  (free_ok),
        .free_st (bus.i_free_st),
        .acc_rd  (st_a),
        .free_rd (st_f),
        .full    (full_now)
    );

    // Registered write port, line announce, status and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            cl_v_q   <= 1'b0;
            cl_st_q  <= '0;
            cl_idx_q <= '0;
            full_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            we_q   <= acc;
            cl_v_q <= acc & st_a.half;
            full_q <= full_now;
            err_q  <= err_q | free_bad;
            if (acc) begin
                wa_q <= mk_addr(bus.i_st, st_a.head, st_a.half);
                wd_q <= bus.i_d;
            end
            if (acc && st_a.half) begin
                cl_st_q  <= bus.i_st;
                cl_idx_q <= st_a.head;
            end
        end
    end

    assign bus.i_r      = rdy;
    assign bus.o_we     = we_q;
    assign bus.o_wa     = wa_q;
    assign bus.o_wd     = wd_q;
    assign bus.o_cl_v   = cl_v_q;
    assign bus.o_cl_st  = cl_st_q;
    assign bus.o_cl_idx = cl_idx_q;
    assign bus.o_full   = full_q;
    assign bus.o_err    = err_q;
endmodule

// File: tb/tb_bram_wr_ctrl.sv
// Directed + random bench for bram_wr_ctrl against a per-stream line model.
module tb_bram_wr_ctrl;
    import bram_wr_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bram_wr_ctrl_if bus();

    bram_wr_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: line slot to fill, half written flag, lines held per stream
    int           m_hd   [16];
    int           m_half [16];
    int           m_cnt  [16];
    logic         m_err;
    logic         e_we, e_clv;
    logic [8:0]   e_wa;
    logic [511:0] e_wd;
    logic [3:0]   e_clst, e_clidx;
    logic [15:0]  e_full;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd_d();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_rst();
        for (int s = 0; s < 16; s++) begin
            m_hd[s] = 0; m_half[s] = 0; m_cnt[s] = 0;
        end
        m_err = 0; e_we = 0; e_clv = 0; e_wa = 0; e_wd = 0;
        e_clst = 0; e_clidx = 0; e_full = 0;
    endtask

    task automatic chk_outs();
        chk("o_we", bus.o_we, e_we);
        chk("o_wa", bus.o_wa, e_wa);
        chk("o_wd", bus.o_wd, e_wd);
        chk("o_cl_v", bus.o_cl_v, e_clv);
        chk("o_cl_st", bus.o_cl_st, e_clst);
        chk("o_cl_idx", bus.o_cl_idx, e_clidx);
        chk("o_full", bus.o_full, e_full);
        chk("o_err", bus.o_err, m_err);
    endtask

    // One clock: drive at negedge, check ready, predict, check registered outputs
    task automatic cyc(input bit v, input int st, input logic [511:0] d,
                       input bit fv, input int fst);
        bit rdy, acc, fok;
        bus.i_v = v; bus.i_st = 4'(st); bus.i_d = d;
        bus.i_free_v = fv; bus.i_free_st = 4'(fst);
        #1;
        rdy = (m_half[st] == 1) || (m_cnt[st] < 16);
        chk("i_r", bus.i_r, rdy);
        acc = v && rdy;
        for (int s = 0; s < 16; s++) e_full[s] = (m_cnt[s] == 16);
        fok = fv && (m_cnt[fst] > 0) && !(m_cnt[fst] == 1 && m_half[fst] == 1);
        if (fv && !fok) m_err = 1;
        e_we = acc;
        e_clv = 0;
        if (acc) begin
            e_wa = 9'(st * 2 * l1_ncl + m_hd[st] * 2 + m_half[st]);
            e_wd = d;
            if (m_half[st] == 1) begin
                e_clv = 1; e_clst = 4'(st); e_clidx = 4'(m_hd[st]);
                m_hd[st] = (m_hd[st] + 1) % l1_ncl;
                m_half[st] = 0;
            end else begin
                m_half[st] = 1;
                m_cnt[st]++;
            end
        end
        if (fok) m_cnt[fst]--;
        @(posedge clk);
        #1;
        chk_outs();
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear without a clock edge
    task automatic do_reset();
        bus.i_v = 0; bus.i_free_v = 0; bus.i_st = 0; bus.i_free_st = 0;
        reset = 1'b1;
        #1;
        model_rst();
        chk_outs();
        chk("i_r_rst", bus.i_r, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.i_v = 0; bus.i_st = 0; bus.i_d = '0; bus.i_free_v = 0; bus.i_free_st = 0;
        model_rst();
        @(negedge clk);
        do_reset();

        // Single line on stream 3
        cyc(1, 3, rnd_d(), 0, 0);
        cyc(1, 3, rnd_d(), 0, 0);
        cyc(0, 3, rnd_d(), 0, 0);

        // Fill stream 5, blocked beat, free, then wrapped head
        for (int i = 0; i < 32; i++) cyc(1, 5, rnd_d(), 0, 0);
        cyc(1, 5, rnd_d(), 0, 0);
        cyc(0, 5, rnd_d(), 1, 5);
        cyc(1, 5, rnd_d(), 0, 0);
        cyc(1, 5, rnd_d(), 0, 0);
        cyc(0, 0, rnd_d(), 0, 0);

        // Interleaved streams 1 and 2
        cyc(1, 1, rnd_d(), 0, 0);
        cyc(1, 2, rnd_d(), 0, 0);
        cyc(1, 1, rnd_d(), 0, 0);
        cyc(1, 2, rnd_d(), 0, 0);

        // Stream 7 full: blocked beat with free, then accept plus free
        for (int i = 0; i < 32; i++) cyc(1, 7, rnd_d(), 0, 0);
        cyc(1, 7, rnd_d(), 1, 7);
        cyc(1, 7, rnd_d(), 1, 7);
        cyc(0, 7, rnd_d(), 0, 0);

        // Free on empty stream 0, sticky error, async clear
        cyc(0, 0, rnd_d(), 1, 0);
        cyc(0, 0, rnd_d(), 0, 0);
        cyc(1, 0, rnd_d(), 0, 0);
        do_reset();

        // Partial line on stream 9 discarded by reset
        cyc(1, 9, rnd_d(), 0, 0);
        do_reset();
        cyc(1, 9, rnd_d(), 0, 0);
        cyc(1, 9, rnd_d(), 0, 0);

        // Random traffic over a few streams to hit full and illegal frees
        for (int i = 0; i < 800; i++)
            cyc(($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)), rnd_d(),
                ($urandom_range(0, 9) < 3), int'($urandom_range(0, 3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
